flash_xfer_arb: RTL and testbench

Parametrised multi-channel front end for the SPI-flash engine. It arbitrates NCH requesters (e.g. DDR copy, parameter load, firmware update) round-robin and latches the granted channel's direction, flash address and word length. It issues a single start to the engine, steers write data in and tagged read data out, counts words, and reports per-channel done, error and busy. It sits between the MCU/DDR/param clients and the AHB-SPI flash engine.

---
 rtl/flash_xfer_arb_if.sv | 56 +++++
 rtl/flash_xfer_arb.sv | 265 ++++++++++++++++++++++++++
 tb/tb_flash_xfer_arb.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_xfer_arb_if.sv
// ----------------------------------------------------------------------------
// flash_xfer_arb_if
// Bundle of every non-clock/reset signal of the flash transfer arbiter.
//   slave  : arbiter view (client requests and engine status in, grants,
//            client data and engine commands out)
//   master : environment view (clients + flash engine), directions mirrored
// Per-channel vectors pack channel k at [k*W +: W].
// ----------------------------------------------------------------------------
interface flash_xfer_arb_if #(
    parameter int NCH = 3,
    parameter int DW  = 16,
    parameter int AW  = 32,
    parameter int LW  = 32
);
    // client side
    logic [NCH-1:0]    i_req;
    logic [NCH-1:0]    i_req_dir;
    logic [NCH*AW-1:0] i_req_faddr;
    logic [NCH*LW-1:0] i_req_len;
    logic [NCH*DW-1:0] i_wr_data;
    logic [NCH-1:0]    i_wr_vld;
    logic [NCH-1:0]    o_wr_req;
    logic [DW-1:0]     o_rd_data;
    logic [NCH-1:0]    o_rd_vld;
    logic [NCH-1:0]    o_grant;
    logic [NCH-1:0]    o_done;
    logic [NCH-1:0]    o_err;
    logic              o_busy;
    // flash engine side
    logic              o_eng_start;
    logic              o_eng_dir;
    logic [AW-1:0]     o_eng_addr;
    logic [LW-1:0]     o_eng_bytes;
    logic              i_eng_wr_req;
    logic [DW-1:0]     o_eng_wr_data;
    logic              o_eng_wr_vld;
    logic [DW-1:0]     i_eng_rd_data;
    logic              i_eng_rd_vld;
    logic              i_eng_idle;

    modport slave (
        input  i_req, i_req_dir, i_req_faddr, i_req_len, i_wr_data, i_wr_vld,
        input  i_eng_wr_req, i_eng_rd_data, i_eng_rd_vld, i_eng_idle,
        output o_wr_req, o_rd_data, o_rd_vld, o_grant, o_done, o_err, o_busy,
        output o_eng_start, o_eng_dir, o_eng_addr, o_eng_bytes,
        output o_eng_wr_data, o_eng_wr_vld
    );

    modport master (
        output i_req, i_req_dir, i_req_faddr, i_req_len, i_wr_data, i_wr_vld,
        output i_eng_wr_req, i_eng_rd_data, i_eng_rd_vld, i_eng_idle,
        input  o_wr_req, o_rd_data, o_rd_vld, o_grant, o_done, o_err, o_busy,
        input  o_eng_start, o_eng_dir, o_eng_addr, o_eng_bytes,
        input  o_eng_wr_data, o_eng_wr_vld
    );
endinterface

// File: rtl/flash_xfer_arb.sv
// ----------------------------------------------------------------------------
// flash_xfer_arb
// Round-robin front end for the SPI-flash engine. Grants one of NCH clients,
// latches its direction/address/length, issues one engine start (after a
// PRE_DLY prefetch wait for writes), steers write data to the engine and
// registered read data back to the granted client, counts words and reports
// per-channel done / timeout error.
// Ports:
//   i_clk  : system clock
//   i_rst  : asynchronous active-high reset
//   bus    : flash_xfer_arb_if.slave (client + engine signals)
// ----------------------------------------------------------------------------
module flash_xfer_arb #(
    parameter int NCH     = 3,
    parameter int DW      = 16,
    parameter int AW      = 32,
    parameter int LW      = 32,
    parameter int PRE_DLY = 4096,
    parameter int TO_W    = 24
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    flash_xfer_arb_if.slave       bus
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW = $clog2(PRE_DLY + 1);
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRE_DLY - 1);
    // One below saturation: ERR is entered exactly as the counter saturates
    localparam logic [TO_W-1:0] TO_LAST  = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_PRE   = 3'd2,
        ST_START = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [IW-1:0]   ptr_r;
    logic [IW-1:0]   gidx_r;
    logic [IW-1:0]   pick_idx_s;
    logic            pick_vld_s;
    logic            dir_r;
    logic [AW-1:0]   addr_r;
    logic [LW-1:0]   len_r;
    logic [LW-1:0]   bytes_r;
    logic [LW-1:0]   len_sel_s;
    logic [LW-1:0]   wcnt_r;
    logic [PW-1:0]   pre_cnt_r;
    logic [TO_W-1:0] to_cnt_r;
    logic            idle_d_r;
    logic            idle_rise_s;
    logic [NCH-1:0]  gsel_s;
    logic            wr_vld_sel_s;
    logic [DW-1:0]   wr_data_sel_s;
    logic            beat_s;
    logic [NCH-1:0]  grant_r, grant_nxt_s;
    logic [NCH-1:0]  done_r, done_nxt_s;
    logic [NCH-1:0]  err_r, err_nxt_s;
    logic            busy_r, busy_nxt_s;
    logic            start_r, start_nxt_s;
    logic [DW-1:0]   rd_data_r;
    logic [NCH-1:0]  rd_vld_r;

    // Round-robin pick: first requester at or after the pointer, wrapping
    always_comb begin
        pick_vld_s = 1'b0;
        pick_idx_s = {IW{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            int cand;
            cand = int'(ptr_r) + i;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end else begin
                cand = cand;
            end
            if (!pick_vld_s && bus.i_req[cand]) begin
                pick_vld_s = 1'b1;
                pick_idx_s = IW'(cand);
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // Granted-channel selects and the engine data-beat qualifier
    always_comb begin
        len_sel_s     = bus.i_req_len[int'(pick_idx_s)*LW +: LW];
        gsel_s        = {{(NCH-1){1'b0}}, 1'b1} << gidx_r;
        wr_vld_sel_s  = bus.i_wr_vld[gidx_r];
        wr_data_sel_s = bus.i_wr_data[int'(gidx_r)*DW +: DW];
        idle_rise_s   = bus.i_eng_idle & ~idle_d_r;
        // Beats past the programmed length are dropped here
        beat_s = (state_r == ST_RUN) && (wcnt_r != {LW{1'b0}}) &&
                 (dir_r ? wr_vld_sel_s : bus.i_eng_rd_vld);
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_vld_s) state_nxt_s = ST_ARB;
                else            state_nxt_s = ST_IDLE;
            end
            ST_ARB: begin
                if (len_r == {LW{1'b0}}) state_nxt_s = ST_DONE;
                else if (dir_r)          state_nxt_s = ST_PRE;
                else                     state_nxt_s = ST_START;
            end
            ST_PRE: begin
                if (pre_cnt_r == PRE_LAST) state_nxt_s = ST_START;
                else                       state_nxt_s = ST_PRE;
            end
            ST_START: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if ((wcnt_r == {LW{1'b0}}) && idle_rise_s) state_nxt_s = ST_DONE;
                else if (!beat_s && (to_cnt_r == TO_LAST)) state_nxt_s = ST_ERR;
                else                                        state_nxt_s = ST_RUN;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            ST_ERR:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode, evaluated on the next state so outputs register cleanly
    always_comb begin
        grant_nxt_s = {NCH{1'b0}};
        done_nxt_s  = {NCH{1'b0}};
        err_nxt_s   = {NCH{1'b0}};
        busy_nxt_s  = 1'b0;
        start_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE: busy_nxt_s = 1'b0;
            ST_ARB:  busy_nxt_s = 1'b1;
            ST_PRE, ST_RUN: begin
                busy_nxt_s  = 1'b1;
                grant_nxt_s = gsel_s;
            end
            ST_START: begin
                busy_nxt_s  = 1'b1;
                grant_nxt_s = gsel_s;
                start_nxt_s = 1'b1;
            end
            ST_DONE: begin
                busy_nxt_s  = 1'b1;
                grant_nxt_s = gsel_s;
                done_nxt_s  = gsel_s;
            end
            ST_ERR: begin
                busy_nxt_s  = 1'b1;
                grant_nxt_s = gsel_s;
                err_nxt_s   = gsel_s;
            end
            default: busy_nxt_s = 1'b0;
        endcase
    end

    // Registered status outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            grant_r <= {NCH{1'b0}};
            done_r  <= {NCH{1'b0}};
            err_r   <= {NCH{1'b0}};
            busy_r  <= 1'b0;
            start_r <= 1'b0;
        end else begin
            grant_r <= grant_nxt_s;
            done_r  <= done_nxt_s;
            err_r   <= err_nxt_s;
            busy_r  <= busy_nxt_s;
            start_r <= start_nxt_s;
        end
    end

    // Grant latch on leaving IDLE; pointer moves past the channel on completion
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            gidx_r  <= {IW{1'b0}};
            ptr_r   <= {IW{1'b0}};
            dir_r   <= 1'b0;
            addr_r  <= {AW{1'b0}};
            len_r   <= {LW{1'b0}};
            bytes_r <= {LW{1'b0}};
        end else begin
            if (state_r == ST_IDLE && pick_vld_s) begin
                gidx_r  <= pick_idx_s;
                dir_r   <= bus.i_req_dir[pick_idx_s];
                addr_r  <= bus.i_req_faddr[int'(pick_idx_s)*AW +: AW];
                len_r   <= len_sel_s;
                bytes_r <= len_sel_s * LW'(DW / 8);
            end
            if (state_r == ST_DONE || state_r == ST_ERR) begin
                ptr_r <= (int'(gidx_r) == NCH - 1) ? {IW{1'b0}} : gidx_r + IW'(1);
            end
        end
    end

    // Word, prefetch-delay and timeout counters plus engine-idle history
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wcnt_r    <= {LW{1'b0}};
            pre_cnt_r <= {PW{1'b0}};
            to_cnt_r  <= {TO_W{1'b0}};
            idle_d_r  <= 1'b0;
        end else begin
            idle_d_r <= bus.i_eng_idle;
            if (state_r == ST_ARB)  wcnt_r <= len_r;
            else if (beat_s)        wcnt_r <= wcnt_r - LW'(1);
            if (state_r == ST_PRE)  pre_cnt_r <= pre_cnt_r + PW'(1);
            else                    pre_cnt_r <= {PW{1'b0}};
            if (state_r == ST_RUN && !beat_s && to_cnt_r != {TO_W{1'b1}})
                to_cnt_r <= to_cnt_r + TO_W'(1);
            else if (state_r == ST_RUN && !beat_s)
                to_cnt_r <= to_cnt_r;
            else
                to_cnt_r <= {TO_W{1'b0}};
        end
    end

    // Registered read return, zero when no beat
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_data_r <= {DW{1'b0}};
            rd_vld_r  <= {NCH{1'b0}};
        end else if (beat_s && !dir_r) begin
            rd_data_r <= bus.i_eng_rd_data;
            rd_vld_r  <= gsel_s;
        end else begin
            rd_data_r <= {DW{1'b0}};
            rd_vld_r  <= {NCH{1'b0}};
        end
    end

    assign bus.o_grant       = grant_r;
    assign bus.o_done        = done_r;
    assign bus.o_err         = err_r;
    assign bus.o_busy        = busy_r;
    assign bus.o_eng_start   = start_r;
    assign bus.o_eng_dir     = dir_r;
    assign bus.o_eng_addr    = addr_r;
    assign bus.o_eng_bytes   = bytes_r;
    assign bus.o_rd_data     = rd_data_r;
    assign bus.o_rd_vld      = rd_vld_r;
    // Write steering is combinational so the engine sees client data same-cycle
    assign bus.o_eng_wr_data = (state_r == ST_RUN) ? wr_data_sel_s : {DW{1'b0}};
    assign bus.o_eng_wr_vld  = beat_s & dir_r;
    assign bus.o_wr_req      = (state_r == ST_RUN) ? (gsel_s & {NCH{bus.i_eng_wr_req}})
                                                   : {NCH{1'b0}};

endmodule

// File: tb/tb_flash_xfer_arb.sv
// ----------------------------------------------------------------------------
// tb_flash_xfer_arb
// Directed bench for flash_xfer_arb (NCH=3, DW=16, PRE_DLY=16, TO_W=8).
// ----------------------------------------------------------------------------
module tb_flash_xfer_arb;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    flash_xfer_arb_if #(.NCH(3), .DW(16), .AW(32), .LW(32)) bus ();

    flash_xfer_arb #(
        .NCH(3), .DW(16), .AW(32), .LW(32), .PRE_DLY(16), .TO_W(8)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for_start(output int n);
        n = 0;
        while (bus.o_eng_start !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if ({bus.o_busy, bus.o_eng_start, bus.o_eng_dir} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected 000", {bus.o_busy, bus.o_eng_start, bus.o_eng_dir});
        end
        n_checks++;
        if ({bus.o_grant, bus.o_done, bus.o_err, bus.o_rd_vld, bus.o_wr_req} !== 15'd0) begin
            n_fail++; $display("FAIL reset_chan: got %h expected 0", {bus.o_grant, bus.o_done, bus.o_err, bus.o_rd_vld, bus.o_wr_req});
        end
        n_checks++;
        if ({bus.o_eng_addr, bus.o_eng_bytes, bus.o_rd_data} !== 80'd0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {bus.o_eng_addr, bus.o_eng_bytes, bus.o_rd_data});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_order [4];
        int n;
        exp_order[0] = 3'b001; exp_order[1] = 3'b010;
        exp_order[2] = 3'b100; exp_order[3] = 3'b001;
        // zero-length jobs keep every channel requesting continuously
        bus.i_req = 3'b111;
        for (int j = 0; j < 4; j++) begin
            n = 0;
            do begin tick(); n++; end while (bus.o_done === 3'b000 && n < 10);
            n_checks++;
            if (bus.o_done !== exp_order[j]) begin
                n_fail++; $display("FAIL rr_order[%0d]: got %b expected %b", j, bus.o_done, exp_order[j]);
            end
        end
        bus.i_req = 3'b000;
        tick(); tick();
        n_checks++;
        if (bus.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL rr_idle: got busy %b expected 0", bus.o_busy);
        end
    endtask

    task automatic test_len0();
        int n;
        logic started;
        started = 1'b0;
        n = 0;
        bus.i_req_len[64 +: 32] = 32'd0;
        bus.i_req = 3'b100;
        do begin
            tick(); n++;
            if (bus.o_eng_start === 1'b1) started = 1'b1;
        end while (bus.o_done === 3'b000 && n < 10);
        n_checks++;
        if (bus.o_done !== 3'b100) begin
            n_fail++; $display("FAIL len0_done: got %b expected 100", bus.o_done);
        end
        n_checks++;
        if (started !== 1'b0) begin
            n_fail++; $display("FAIL len0_nostart: got start %b expected 0", started);
        end
        bus.i_req = 3'b000;
        tick();
    endtask

    task automatic test_read();
        bus.i_req_dir[0] = 1'b0;
        bus.i_req_faddr[0 +: 32] = 32'h0000_1000;
        bus.i_req_len[0 +: 32] = 32'd8;
        bus.i_eng_idle = 1'b1;
        bus.i_req = 3'b001;
        tick(); // ARB
        n_checks++;
        if ({bus.o_busy, bus.o_grant, bus.o_eng_start} !== 5'b1_000_0) begin
            n_fail++; $display("FAIL rd_arb: got %b expected 10000", {bus.o_busy, bus.o_grant, bus.o_eng_start});
        end
        tick(); // START one cycle after ARB
        n_checks++;
        if ({bus.o_eng_start, bus.o_grant, bus.o_eng_dir} !== 5'b1_001_0) begin
            n_fail++; $display("FAIL rd_start: got %b expected 10010", {bus.o_eng_start, bus.o_grant, bus.o_eng_dir});
        end
        n_checks++;
        if (bus.o_eng_addr !== 32'h1000 || bus.o_eng_bytes !== 32'd16) begin
            n_fail++; $display("FAIL rd_params: got addr %h bytes %0d expected 1000 16", bus.o_eng_addr, bus.o_eng_bytes);
        end
        tick(); // RUN
        n_checks++;
        if (bus.o_eng_start !== 1'b0) begin
            n_fail++; $display("FAIL rd_start_pulse: got %b expected 0", bus.o_eng_start);
        end
        bus.i_eng_idle = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.i_eng_rd_data = 16'hA5A0 + 16'(i);
            bus.i_eng_rd_vld = 1'b1;
            tick();
            n_checks++;
            if (bus.o_rd_vld !== 3'b001 || bus.o_rd_data !== 16'hA5A0 + 16'(i)) begin
                n_fail++; $display("FAIL rd_beat[%0d]: got vld %b data %h expected 001 %h", i, bus.o_rd_vld, bus.o_rd_data, 16'hA5A0 + 16'(i));
            end
        end
        // ninth beat exceeds the length and must be dropped
        bus.i_eng_rd_data = 16'hDEAD;
        tick();
        n_checks++;
        if (bus.o_rd_vld !== 3'b000 || bus.o_rd_data !== 16'h0000) begin
            n_fail++; $display("FAIL rd_extra_drop: got vld %b data %h expected 000 0000", bus.o_rd_vld, bus.o_rd_data);
        end
        bus.i_eng_rd_vld = 1'b0;
        bus.i_eng_idle = 1'b1;
        tick();
        n_checks++;
        if (bus.o_done !== 3'b001) begin
            n_fail++; $display("FAIL rd_done: got %b expected 001", bus.o_done);
        end
        bus.i_req = 3'b000;
        tick();
        n_checks++;
        if ({bus.o_busy, bus.o_done} !== 4'b0000) begin
            n_fail++; $display("FAIL rd_back_idle: got %b expected 0000", {bus.o_busy, bus.o_done});
        end
    endtask

    task automatic test_write();
        int n;
        bus.i_req_dir[1] = 1'b1;
        bus.i_req_faddr[32 +: 32] = 32'h0000_2000;
        bus.i_req_len[32 +: 32] = 32'd4;
        bus.i_wr_data[16 +: 16] = 16'hBEE0;
        bus.i_wr_vld = 3'b010;
        bus.i_eng_wr_req = 1'b1;
        bus.i_req = 3'b010;
        tick(); // ARB
        tick(); // first PRE cycle: grant visible, no data may pass yet
        n_checks++;
        if ({bus.o_grant, bus.o_wr_req, bus.o_eng_wr_vld} !== 7'b010_000_0) begin
            n_fail++; $display("FAIL wr_pre_gate: got %b expected 0100000", {bus.o_grant, bus.o_wr_req, bus.o_eng_wr_vld});
        end
        n = 0;
        while (bus.o_eng_start !== 1'b1 && n < 40) begin tick(); n++; end
        n_checks++;
        if (n !== 16) begin
            n_fail++; $display("FAIL wr_pre_delay: got %0d cycles expected 16", n);
        end
        n_checks++;
        if (bus.o_eng_dir !== 1'b1 || bus.o_eng_bytes !== 32'd8 || bus.o_eng_addr !== 32'h2000) begin
            n_fail++; $display("FAIL wr_params: got dir %b bytes %0d addr %h expected 1 8 2000", bus.o_eng_dir, bus.o_eng_bytes, bus.o_eng_addr);
        end
        tick(); // RUN
        bus.i_req = 3'b000; // dropping the request mid-transfer has no effect
        bus.i_eng_idle = 1'b0;
        #1;
        n_checks++;
        if (bus.o_wr_req !== 3'b010) begin
            n_fail++; $display("FAIL wr_req_high: got %b expected 010", bus.o_wr_req);
        end
        bus.i_eng_wr_req = 1'b0;
        #1;
        n_checks++;
        if (bus.o_wr_req !== 3'b000) begin
            n_fail++; $display("FAIL wr_req_low: got %b expected 000", bus.o_wr_req);
        end
        for (int i = 0; i < 4; i++) begin
            bus.i_wr_data[16 +: 16] = 16'hBEE0 + 16'(i);
            #1;
            n_checks++;
            if (bus.o_eng_wr_vld !== 1'b1 || bus.o_eng_wr_data !== 16'hBEE0 + 16'(i)) begin
                n_fail++; $display("FAIL wr_beat[%0d]: got vld %b data %h expected 1 %h", i, bus.o_eng_wr_vld, bus.o_eng_wr_data, 16'hBEE0 + 16'(i));
            end
            tick();
        end
        #1;
        n_checks++;
        if (bus.o_eng_wr_vld !== 1'b0) begin
            n_fail++; $display("FAIL wr_extra_drop: got %b expected 0", bus.o_eng_wr_vld);
        end
        bus.i_wr_vld = 3'b000;
        bus.i_eng_idle = 1'b1;
        tick();
        n_checks++;
        if (bus.o_done !== 3'b010) begin
            n_fail++; $display("FAIL wr_done: got %b expected 010", bus.o_done);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        int m;
        bus.i_req_dir[0] = 1'b0;
        bus.i_req_len[0 +: 32] = 32'd2;
        bus.i_eng_idle = 1'b1;
        bus.i_req = 3'b001;
        wait_for_start(n);
        n_checks++;
        if (bus.o_eng_start !== 1'b1) begin
            n_fail++; $display("FAIL to_start: got %b expected 1 after %0d cycles", bus.o_eng_start, n);
        end
        // start cycle plus 255 silent RUN cycles, then the ERR cycle
        m = 0;
        while (bus.o_err === 3'b000 && m < 400) begin tick(); m++; end
        n_checks++;
        if (m !== 256 || bus.o_err !== 3'b001) begin
            n_fail++; $display("FAIL to_err: got %0d cycles err %b expected 256 001", m, bus.o_err);
        end
        n_checks++;
        if (bus.o_done !== 3'b000) begin
            n_fail++; $display("FAIL to_nodone: got %b expected 000", bus.o_done);
        end
        bus.i_req = 3'b000;
        tick();
        n_checks++;
        if ({bus.o_busy, bus.o_err} !== 4'b0000) begin
            n_fail++; $display("FAIL to_idle: got %b expected 0000", {bus.o_busy, bus.o_err});
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        bus.i_req_dir[1] = 1'b0;
        bus.i_req_len[32 +: 32] = 32'd4;
        bus.i_req = 3'b010;
        wait_for_start(n);
        tick(); // RUN
        bus.i_eng_idle = 1'b0;
        bus.i_eng_rd_data = 16'h5A5A;
        bus.i_eng_rd_vld = 1'b1;
        tick();
        bus.i_eng_rd_vld = 1'b0;
        n_checks++;
        if (bus.o_rd_vld !== 3'b010) begin
            n_fail++; $display("FAIL rst_pre_beat: got %b expected 010", bus.o_rd_vld);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.o_busy, bus.o_grant, bus.o_rd_vld, bus.o_done, bus.o_err, bus.o_wr_req, bus.o_eng_start, bus.o_eng_wr_vld} !== 18'd0) begin
            n_fail++; $display("FAIL rst_mid_ctl: got %b expected 0", {bus.o_busy, bus.o_grant, bus.o_rd_vld, bus.o_done, bus.o_err, bus.o_wr_req, bus.o_eng_start, bus.o_eng_wr_vld});
        end
        n_checks++;
        if ({bus.o_rd_data, bus.o_eng_addr, bus.o_eng_bytes} !== 80'd0) begin
            n_fail++; $display("FAIL rst_mid_data: got %h expected 0", {bus.o_rd_data, bus.o_eng_addr, bus.o_eng_bytes});
        end
        bus.i_req = 3'b000;
        bus.i_eng_idle = 1'b1;
        tick();
        rst = 1'b0;
        tick(); tick();
        n_checks++;
        if ({bus.o_busy, bus.o_eng_start, bus.o_done, bus.o_err} !== 8'd0) begin
            n_fail++; $display("FAIL rst_no_restart: got %b expected 0", {bus.o_busy, bus.o_eng_start, bus.o_done, bus.o_err});
        end
        // a fresh request after release is served normally
        bus.i_req_dir[2] = 1'b0;
        bus.i_req_len[64 +: 32] = 32'd1;
        bus.i_req = 3'b100;
        wait_for_start(n);
        n_checks++;
        if (bus.o_eng_start !== 1'b1 || bus.o_grant !== 3'b100) begin
            n_fail++; $display("FAIL rst_new_start: got start %b grant %b expected 1 100", bus.o_eng_start, bus.o_grant);
        end
        tick();
        bus.i_eng_idle = 1'b0;
        bus.i_eng_rd_data = 16'h1234;
        bus.i_eng_rd_vld = 1'b1;
        tick();
        bus.i_eng_rd_vld = 1'b0;
        n_checks++;
        if (bus.o_rd_vld !== 3'b100 || bus.o_rd_data !== 16'h1234) begin
            n_fail++; $display("FAIL rst_new_beat: got vld %b data %h expected 100 1234", bus.o_rd_vld, bus.o_rd_data);
        end
        bus.i_eng_idle = 1'b1;
        tick();
        n_checks++;
        if (bus.o_done !== 3'b100) begin
            n_fail++; $display("FAIL rst_new_done: got %b expected 100", bus.o_done);
        end
        bus.i_req = 3'b000;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.i_req = 3'b000;
        bus.i_req_dir = 3'b000;
        bus.i_req_faddr = '0;
        bus.i_req_len = '0;
        bus.i_wr_data = '0;
        bus.i_wr_vld = 3'b000;
        bus.i_eng_wr_req = 1'b0;
        bus.i_eng_rd_data = 16'h0000;
        bus.i_eng_rd_vld = 1'b0;
        bus.i_eng_idle = 1'b1;
        test_reset();
        test_round_robin();
        test_len0();
        test_read();
        test_write();
        test_timeout();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
